// File: rtl/scalar_and_pkg.sv
// Shared definitions for the scalar-AND round-robin arbiter: FSM encoding and
// default operand width / requester count.
package scalar_and_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int N_DEF = 4;
  localparam int R_DEF = 4;

endpackage

// File: rtl/scalar_and_arbiter_if.sv
// Requester/result bundle for scalar_and_arbiter; master is the environment
// (requesters + downstream consumer), slave is the arbiter itself.
interface scalar_and_arbiter_if
  import scalar_and_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int R = R_DEF
);

  localparam int IW = $clog2(R);

  logic [R-1:0]   req;
  logic [R-1:0]   g;
  logic [R*N-1:0] a;
  logic [R-1:0]   gnt;
  logic [N-1:0]   y;
  logic [IW-1:0]  y_id;
  logic           y_valid;
  logic           y_ready;

  modport master (
    output req, g, a, y_ready,
    input  gnt, y, y_id, y_valid
  );

  modport slave (
    input  req, g, a, y_ready,
    output gnt, y, y_id, y_valid
  );

endinterface

// File: rtl/scalar_gate.sv
// Combinational datapath: N-bit vector bitwise-ANDed with a replicated scalar.
module scalar_gate
  import scalar_and_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] operand,
  input  logic         gate,
  output logic [N-1:0] result
);

  assign result = operand & {N{gate}};

endmodule

// File: rtl/scalar_and_arbiter.sv
// Round-robin arbiter feeding a one-deep result slot; the granted operand is
// gated by its scalar bit and registered with the winner's index.
//
//   state | meaning
//   EMPTY | slot holds no result, y_valid low
//   FULL  | slot holds an unconsumed result, y_valid high
module scalar_and_arbiter
  import scalar_and_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int R = R_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  scalar_and_arbiter_if.slave  bus
);

  localparam int IW = $clog2(R);

  state_t        state, state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] idx;
  logic          grant_hit;
  logic          slot_free;
  logic [N-1:0]  a_sel;
  logic [N-1:0]  y_gated;

  // Search starts at ptr; R is a power of two so IW-bit addition wraps for free.
  // rst_n gating keeps gnt low while reset is held.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    idx       = '0;
    slot_free = (state == EMPTY) || bus.y_ready;
    for (int i = 0; i < R; i++) begin
      idx = ptr + IW'(i);
      if (!grant_hit && bus.req[idx]) begin
        grant_hit = 1'b1;
        grant_idx = idx;
      end
    end
    grant_hit = grant_hit & slot_free & rst_n;
  end

  always_comb begin
    bus.gnt = '0;
    if (grant_hit) bus.gnt[grant_idx] = 1'b1;
  end

  assign a_sel = bus.a[int'(grant_idx)*N +: N];

  scalar_gate #(.N(N)) u_gate (
    .operand (a_sel),
    .gate    (bus.g[grant_idx]),
    .result  (y_gated)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.y_valid = 1'b0;
    case (state)
      EMPTY: begin
        if (grant_hit) state_nxt = FULL;
      end
      FULL: begin
        bus.y_valid = 1'b1;
        if (grant_hit)        state_nxt = FULL;
        else if (bus.y_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // y and y_id only move on a grant, so they persist after the slot drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.y    <= '0;
      bus.y_id <= '0;
      ptr      <= '0;
    end else if (grant_hit) begin
      bus.y    <= y_gated;
      bus.y_id <= grant_idx;
      ptr      <= grant_idx + IW'(1);
    end
  end

endmodule

// File: doc/scalar_and_arbiter.md
SCALAR_AND_ARBITER -- requirements
Module: scalar_and_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the data width of each operand and of the result.
REQ-002 The block SHALL have parameter R, default 4, giving the number of requesters; R SHALL be a power of two, at least 2.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  R  per-requester request; bit k high means requester k presents an operand.
REQ-007 g  input  R  per-requester scalar gate bit.
REQ-008 a  input  R*N  per-requester vector operand; requester k occupies bits [k*N+N-1 : k*N].
REQ-009 gnt  output  R  one-hot (or zero) grant; combinational; gnt[k] high means requester k's operand is taken at this clock edge.
REQ-010 y  output  N  registered result.
REQ-011 y_id  output  log2(R)  index of the requester that produced y.
REQ-012 y_valid  output  1  y and y_id hold an unconsumed result.
REQ-013 y_ready  input  1  downstream accepts the result when y_valid and y_ready are both high at a clock edge.

Function
REQ-014 The block SHALL be a two-state FSM: EMPTY (y_valid=0) and FULL (y_valid=1).
REQ-015 Slot-free condition: state EMPTY, or state FULL with y_ready=1.
REQ-016 gnt SHALL be nonzero only when the slot is free and req is nonzero; otherwise gnt=0.
REQ-017 The grant SHALL be round-robin: search starts at index ptr, wraps from R-1 to 0, and picks the first k with req[k]=1.
REQ-018 On a grant to k: ptr becomes (k+1) mod R at the edge; with no grant, ptr is unchanged.
REQ-019 On a granted edge: y <= a_k AND {N{g[k]}} bitwise, y_id <= k, y_valid <= 1 (state FULL).
REQ-020 Latency: the result is visible one cycle after the grant cycle; throughput is one result per cycle while y_ready=1.
REQ-021 FULL with y_ready=1 and no request: next state EMPTY, y_valid <= 0; y and y_id keep their last value.
REQ-022 FULL with y_ready=0: y, y_id and y_valid SHALL hold unchanged and gnt=0.
REQ-023 Simultaneous consume and grant in FULL: the new result replaces the old at the same edge, with no bubble.
REQ-024 gnt SHALL depend only on current-cycle req, y_ready, state and ptr; there is no combinational path from a or g to gnt.
REQ-025 Requesters SHALL hold req, g and a stable until they see their gnt; the block does not latch unrequested operands.

Reset
REQ-026 While rst_n=0, all outputs and state SHALL be forced asynchronously: state EMPTY, y_valid=0, y=0, y_id=0, ptr=0, gnt=0.
REQ-027 Reset asserted mid-operation SHALL discard any held result with no output pulse.
REQ-028 The first edge after reset release may grant, with requester 0 at top priority.

Structure
REQ-029 A shared package scalar_and_pkg SHALL hold the FSM state encoding (EMPTY=0, FULL=1) and the default values of N and R.
REQ-030 The gating datapath (N-bit vector AND scalar) SHALL be a separate combinational sub-module, scalar_gate, instanced once on the selected operand.
REQ-031 The round-robin select SHALL be written as a loop over R, with no hard-coded requester count.

Verification (N=4, R=4)
REQ-032 Single request, gate on: req=0001, g=0001, a[3:0]=4'hA, y_ready=1 -> gnt=0001 in the same cycle; next cycle y_valid=1, y=4'hA, y_id=0.
REQ-033 Gate off: req=0100, g=0000, a[11:8]=4'hF -> gnt=0100; next cycle y=4'h0, y_id=2, y_valid=1.
REQ-034 All requesting, y_ready=1, after reset -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; y_id sequence 0,1,2,3,0 one cycle later.
REQ-035 Backpressure: y_valid=1, y=4'h5, y_ready=0 for 3 cycles with req=1111 -> gnt=0000 and y=4'h5 held for all 3 cycles; in the cycle y_ready rises, gnt goes nonzero and y updates at that edge.
REQ-036 Wrap-around: last grant to requester 3, then req=1010 -> grant 0010, then 1000.
REQ-037 Reset mid-FULL: rst_n low while y_valid=1 -> y_valid=0, y=0 without waiting for a clock edge; after release, req=1001 grants 0001 first.
